// File: rtl/add_round_key_192_if.sv
// ----------------------------------------------------------------------------
// add_round_key_192_if
//   Bundles the AddRoundKey stage's key-file write port, upstream state
//   handshake and downstream result handshake into a single interface.
//
//   Signals
//     key_we / key_addr / key_wdata  : key-file write port (key schedule side)
//     blk_start                      : next accepted beat starts a new block
//     in_valid / in_ready / in_data  : upstream state beat (from MixColumns)
//     out_valid / out_ready          : downstream result handshake
//     out_data / out_round / out_last: result beat and its round tag
//
//   Modports
//     master : the environment driving the stage (key schedule, upstream,
//              downstream ready)
//     slave  : the AddRoundKey stage itself
// ----------------------------------------------------------------------------
interface add_round_key_192_if #(
    parameter int BLK_W  = 192,
    parameter int KEY_AW = 4
);
    logic              key_we;
    logic [KEY_AW-1:0] key_addr;
    logic [BLK_W-1:0]  key_wdata;
    logic              blk_start;
    logic              in_valid;
    logic              in_ready;
    logic [BLK_W-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [BLK_W-1:0]  out_data;
    logic [KEY_AW-1:0] out_round;
    logic              out_last;

    modport master (
        output key_we, key_addr, key_wdata, blk_start,
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_round, out_last
    );

    modport slave (
        input  key_we, key_addr, key_wdata, blk_start,
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_round, out_last
    );
endinterface

// File: rtl/add_round_key_192.sv
// ----------------------------------------------------------------------------
// add_round_key_192
//   Pipelined AddRoundKey stage following the 192-bit (six-column) MixColumns
//   stage. Every accepted state beat is XORed with the round key selected by
//   an internal round counter and presented one cycle later, tagged with its
//   round number. Round keys 0..NR live in a key file written by the key
//   schedule; the file is cleared by reset.
//
//   Ports
//     clk    : single clock, rising edge
//     rst_n  : asynchronous, active-low reset
//     bus    : add_round_key_192_if.slave (key write port, in_* and out_*
//              handshakes, blk_start)
//
//   Build option
//     ARK_SKID_EN defined   : 2-entry skid buffer on the output; in_ready is a
//                             flop output, low only when both entries are full.
//     ARK_SKID_EN undefined : single output register; in_ready is
//                             !out_valid || out_ready (combinational).
//   Both builds have 1-cycle latency and sustain 1 beat/cycle.
// ----------------------------------------------------------------------------
module add_round_key_192 #(
    parameter int BLK_W  = 192,
    parameter int NR     = 12,
    parameter int KEY_AW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    add_round_key_192_if.slave   bus
);

    localparam int                NKEYS      = NR + 1;
    localparam logic [KEY_AW-1:0] ROUND_ONE  = KEY_AW'(1);
    localparam logic [KEY_AW-1:0] ROUND_LAST = KEY_AW'(NR);

    // ------------------------------------------------------------------
    // Key file. Held in flops because reset must clear every entry.
    // Writes to addresses above NR match no entry and are dropped.
    // ------------------------------------------------------------------
    logic [BLK_W-1:0] key_q [NKEYS];
    logic [NKEYS-1:0] key_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_key_hit
            assign key_hit[gi] = bus.key_we && (bus.key_addr == KEY_AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NKEYS; i++) begin
                key_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                if (key_hit[i]) begin
                    key_q[i] <= bus.key_wdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Round counter and beat formation.
    // blk_start overrides the counter for the beat accepted in the same
    // cycle, so that beat is round 1 and the counter continues from 2.
    // The key is read from the registered file, so a same-cycle write to
    // the selected entry is not seen by this beat.
    // ------------------------------------------------------------------
    logic [KEY_AW-1:0] rcnt_q;
    logic [KEY_AW-1:0] rcnt_d;
    logic [KEY_AW-1:0] beat_round;
    logic [BLK_W-1:0]  beat_data;
    logic              beat_last;
    logic              in_ready_w;
    logic              accept;

    assign beat_round = bus.blk_start ? ROUND_ONE : rcnt_q;
    assign beat_data  = bus.in_data ^ key_q[beat_round];
    assign beat_last  = (beat_round == ROUND_LAST);
    assign accept     = bus.in_valid && in_ready_w;

    always_comb begin
        rcnt_d = rcnt_q;
        if (accept) begin
            rcnt_d = beat_last ? ROUND_ONE : (beat_round + ROUND_ONE);
        end else if (bus.blk_start) begin
            rcnt_d = ROUND_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q <= ROUND_ONE;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end

`ifdef ARK_SKID_EN
    // ------------------------------------------------------------------
    // Two-entry skid buffer. The head entry drives out_*; in_ready is
    // registered from the next occupancy, so out_ready has no
    // combinational path to in_ready. With one entry held and a transfer
    // every cycle the occupancy stays at one, giving full throughput.
    // ------------------------------------------------------------------
    logic [BLK_W-1:0]  fifo_data_q  [2];
    logic [KEY_AW-1:0] fifo_round_q [2];
    logic              fifo_last_q  [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              in_ready_q;
    logic              pop;

    assign pop        = (count_q != 2'd0) && bus.out_ready;
    assign in_ready_w = in_ready_q;

    always_comb begin
        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i]  <= '0;
                fifo_round_q[i] <= '0;
                fifo_last_q[i]  <= 1'b0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            if (accept) begin
                fifo_data_q[wr_ptr_q]  <= beat_data;
                fifo_round_q[wr_ptr_q] <= beat_round;
                fifo_last_q[wr_ptr_q]  <= beat_last;
                wr_ptr_q               <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_d;
            in_ready_q <= (count_d != 2'd2);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = fifo_data_q[rd_ptr_q];
    assign bus.out_round = fifo_round_q[rd_ptr_q];
    assign bus.out_last  = fifo_last_q[rd_ptr_q];
`else
    // ------------------------------------------------------------------
    // Single output register. A new beat may load whenever the register
    // is empty or is being drained this cycle; otherwise the contents
    // hold, keeping out_* stable under backpressure.
    // ------------------------------------------------------------------
    logic              out_valid_q;
    logic [BLK_W-1:0]  out_data_q;
    logic [KEY_AW-1:0] out_round_q;
    logic              out_last_q;

    assign in_ready_w = !out_valid_q || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_round_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= beat_data;
                out_round_q <= beat_round;
                out_last_q  <= beat_last;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_round = out_round_q;
    assign bus.out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_add_round_key_192.sv
module tb_add_round_key_192;
    localparam int BLK_W  = 192;
    localparam int NR     = 12;
    localparam int KEY_AW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    add_round_key_192_if #(.BLK_W(BLK_W), .KEY_AW(KEY_AW)) bus ();

    add_round_key_192 #(.BLK_W(BLK_W), .NR(NR), .KEY_AW(KEY_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [BLK_W-1:0]  data;
        logic [KEY_AW-1:0] round;
        logic              last;
    } beat_t;

    logic [BLK_W-1:0] m_key [NR+1];
    int               m_rcnt;
    beat_t            m_q [$];
    int               acc_cnt = 0;
    bit               last_acc = 0;

    // explicit per-beat expectation checked on the cycle after acceptance
    bit                pend = 0;
    string             pend_name;
    logic [BLK_W-1:0]  pend_data;
    logic [KEY_AW-1:0] pend_round;
    logic              pend_last;

    typedef struct {
        logic [BLK_W-1:0]  din;
        logic [BLK_W-1:0]  exp_data;
        logic [KEY_AW-1:0] exp_round;
        logic              exp_last;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(string name, logic [BLK_W-1:0] act, logic [BLK_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BLK_W-1:0] keyval(int r);
        logic [7:0] b;
        b = 8'(r * 17);
        return {24{b}};
    endfunction

    function automatic logic [BLK_W-1:0] rand192();
        logic [BLK_W-1:0] v;
        for (int w = 0; w < 6; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i <= NR; i++) m_key[i] = '0;
        m_rcnt = 1;
        m_q.delete();
    endtask

    task automatic set_pend(string name, logic [BLK_W-1:0] d, int r, logic l);
        if (!last_acc) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got not-accepted expected accepted", name);
        end else begin
            pend       = 1;
            pend_name  = name;
            pend_data  = d;
            pend_round = KEY_AW'(r);
            pend_last  = l;
        end
    endtask

    // One clock: check outputs against the model mid-cycle, advance the
    // model for the coming edge, then step past the edge.
    task automatic cycle();
        bit    exp_rdy;
        int    r;
        beat_t b;
        @(negedge clk);
        chk("out_valid", BLK_W'(bus.out_valid), BLK_W'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("out_data",  bus.out_data, m_q[0].data);
            chk("out_round", BLK_W'(bus.out_round), BLK_W'(m_q[0].round));
            chk("out_last",  BLK_W'(bus.out_last), BLK_W'(m_q[0].last));
        end
`ifdef ARK_SKID_EN
        exp_rdy = (m_q.size() < 2);
`else
        exp_rdy = (m_q.size() == 0) || bus.out_ready;
`endif
        chk("in_ready", BLK_W'(bus.in_ready), BLK_W'(exp_rdy));
        if (pend) begin
            chk({pend_name, "_data"},  bus.out_data, pend_data);
            chk({pend_name, "_round"}, BLK_W'(bus.out_round), BLK_W'(pend_round));
            chk({pend_name, "_last"},  BLK_W'(bus.out_last), BLK_W'(pend_last));
            pend = 0;
        end
        if (m_q.size() != 0 && bus.out_ready) void'(m_q.pop_front());
        if (bus.in_valid && exp_rdy) begin
            r = bus.blk_start ? 1 : m_rcnt;
            b.data  = bus.in_data ^ m_key[r];
            b.round = KEY_AW'(r);
            b.last  = (r == NR);
            m_q.push_back(b);
            m_rcnt   = (r == NR) ? 1 : r + 1;
            acc_cnt++;
            last_acc = 1;
        end else begin
            last_acc = 0;
            if (bus.blk_start) m_rcnt = 1;
        end
        if (bus.key_we && bus.key_addr <= KEY_AW'(NR)) m_key[bus.key_addr] = bus.key_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.key_we    = 0;
        bus.blk_start = 0;
        bus.in_valid  = 0;
    endtask

    initial begin
        int a0;
        int rs [5];
        logic [BLK_W-1:0] d;

        rst_n         = 0;
        bus.key_we    = 0;
        bus.key_addr  = '0;
        bus.key_wdata = '0;
        bus.blk_start = 0;
        bus.in_valid  = 0;
        bus.in_data   = '0;
        bus.out_ready = 1;
        model_reset();

        // table: 12 zero beats return key[1..12], 13th wraps to round 1
        for (int i = 0; i < 13; i++) begin
            int r;
            r = (i % NR) + 1;
            tbl[i].din       = (i < 12) ? '0 : rand192();
            tbl[i].exp_round = KEY_AW'(r);
            tbl[i].exp_data  = tbl[i].din ^ keyval(r);
            tbl[i].exp_last  = (r == NR);
        end

        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", BLK_W'(bus.out_valid), '0);
        chk("rst_out_data",  bus.out_data, '0);
        chk("rst_out_round", BLK_W'(bus.out_round), '0);
        chk("rst_out_last",  BLK_W'(bus.out_last), '0);
        chk("rst_in_ready",  BLK_W'(bus.in_ready), BLK_W'(1));
        rst_n = 1;

        // load keys, plus out-of-range writes that must be ignored
        for (int r = 0; r <= NR + 3; r++) begin
            bus.key_we    = 1;
            bus.key_addr  = KEY_AW'(r);
            bus.key_wdata = (r <= NR) ? keyval(r) : '1;
            cycle();
        end
        idle_inputs();
        cycle();

        // tests 1 and 2: 13 consecutive beats
        for (int i = 0; i < 13; i++) begin
            bus.in_valid = 1;
            bus.in_data  = tbl[i].din;
            cycle();
            set_pend($sformatf("tbl%0d", i), tbl[i].exp_data, int'(tbl[i].exp_round), tbl[i].exp_last);
        end
        idle_inputs();
        cycle();

        // test 3: backpressure
        bus.out_ready = 0;
        a0 = acc_cnt;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1;
            bus.in_data  = rand192();
            cycle();
        end
`ifdef ARK_SKID_EN
        chk("stall_accepts", BLK_W'(acc_cnt - a0), BLK_W'(2));
`else
        chk("stall_accepts", BLK_W'(acc_cnt - a0), BLK_W'(1));
`endif
        chk("stall_in_ready", BLK_W'(bus.in_ready), '0);
        idle_inputs();
        bus.out_ready = 1;
        for (int k = 0; k < 3; k++) cycle();

        // test 4: same-cycle key write to the accepted beat's round
        bus.key_we    = 1;
        bus.key_addr  = KEY_AW'(1);
        bus.key_wdata = '1;
        bus.blk_start = 1;
        bus.in_valid  = 1;
        bus.in_data   = '0;
        cycle();
        set_pend("oldkey", keyval(1), 1, 0);
        bus.key_we = 0;
        cycle();
        set_pend("newkey", '1, 1, 0);
        idle_inputs();
        cycle();

        // test 5: blk_start after three beats (counter currently at 2)
        rs = '{2, 3, 4, 1, 2};
        for (int k = 0; k < 5; k++) begin
            bus.in_valid  = 1;
            bus.in_data   = '0;
            bus.blk_start = (k == 3);
            cycle();
            set_pend($sformatf("blk%0d", k), (rs[k] == 1) ? '1 : keyval(rs[k]), rs[k], 0);
        end
        idle_inputs();
        cycle();

        // test 6: asynchronous reset while out_valid is high
        bus.out_ready = 0;
        bus.in_valid  = 1;
        bus.in_data   = rand192();
        cycle();
        idle_inputs();
        #2;
        chk("pre_rst_out_valid", BLK_W'(bus.out_valid), BLK_W'(1));
        rst_n = 0;
        #1;
        chk("async_out_valid", BLK_W'(bus.out_valid), '0);
        chk("async_out_round", BLK_W'(bus.out_round), '0);
        chk("async_out_data",  bus.out_data, '0);
        chk("async_in_ready",  BLK_W'(bus.in_ready), BLK_W'(1));
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        bus.out_ready = 1;
        d = rand192();
        bus.in_valid = 1;
        bus.in_data  = d;
        cycle();
        set_pend("post_rst", d, 1, 0);
        idle_inputs();
        cycle();

        // randomized traffic against the model
        for (int r = 0; r <= NR; r++) begin
            bus.key_we    = 1;
            bus.key_addr  = KEY_AW'(r);
            bus.key_wdata = rand192();
            cycle();
        end
        for (int k = 0; k < 400; k++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = rand192();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.blk_start = ($urandom_range(0, 15) == 0);
            bus.key_we    = ($urandom_range(0, 7) == 0);
            bus.key_addr  = KEY_AW'($urandom_range(0, 15));
            bus.key_wdata = rand192();
            cycle();
        end
        idle_inputs();
        bus.out_ready = 1;
        for (int k = 0; k < 4; k++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
